// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit-FIFO state encoding
// Contents:
//   UART_DW          character width, matching the transmitter data input
//   tx_fifo_state_e  launch sequencer states: IDLE, LAUNCH, BUSY
package uart_pkg;

    localparam int UART_DW = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_fifo_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with level counter, flush and sticky overflow
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   clear_i              synchronous flush of pointers, level and overflow flag
//   wr_en_i, wr_data_i   push request and data
//   rd_en_i              pop request (ignored while empty or flushing)
//   rd_data_o            head entry, combinational read of the storage array
//   full_o, empty_o      level_o == DEPTH / level_o == 0
//   level_o              entries held
//   overflow_o           sticky: push attempted while full
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 9
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [DW-1:0]                wr_data_i,
    input  logic                         rd_en_i,
    output logic [DW-1:0]                rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q;
    logic          push, pop;

    assign full_o     = (level_q == LW'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];

    // full_o is taken before any same-cycle pop, so a push into a full FIFO is
    // dropped even when a slot frees up on the same edge. Flush wins over both.
    assign push = wr_en_i & ~full_o  & ~clear_i;
    assign pop  = rd_en_i & ~empty_o & ~clear_i;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            if (wr_en_i && full_o) overflow_q <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit character queue and launch sequencer for the UART transmitter
// Optional feature macro: UART_TX_FIFO_WM_EN (adds wm_level_i / tx_wm_o low watermark).
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   en_i                   UART enable; no new launch while low
//   clear_i                flush queue and overflow flag
//   wr_en_i, wr_data_i     bus-side character push
//   full_o, empty_o        queue status
//   level_o                entries held
//   overflow_o             sticky push-while-full flag
//   tx_start_o, tx_data_o  launch request and head character to the transmitter
//   tx_rdy_i               transmitter idle; falling edge means character accepted
//   wm_level_i, tx_wm_o    (macro only) tx_wm_o = registered (level_o <= wm_level_i)
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = UART_DW
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic                         clear_i,
    input  logic                         wr_en_i,
    input  logic [DW-1:0]                wr_data_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         overflow_o,
    output logic                         tx_start_o,
    output logic [DW-1:0]                tx_data_o,
    input  logic                         tx_rdy_i
`ifdef UART_TX_FIFO_WM_EN
    ,
    input  logic [$clog2(DEPTH+1)-1:0]   wm_level_i,
    output logic                         tx_wm_o
`endif
);

    tx_fifo_state_e state_q;
    logic           tx_start_q;
    logic           accept;

    // Acceptance is the transmitter dropping tx_rdy_i while the start is offered.
    // A flush on that same edge suppresses the pop inside the FIFO; the
    // character already captured by the transmitter still goes out.
    assign accept     = (state_q == LAUNCH) & ~tx_rdy_i;
    assign tx_start_o = tx_start_q;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .rd_en_i    (accept),
        .rd_data_o  (tx_data_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .overflow_o (overflow_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty_o && en_i && tx_rdy_i && !clear_i) begin
                        state_q    <= LAUNCH;
                        tx_start_q <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (!tx_rdy_i) begin
                        state_q    <= BUSY;
                        tx_start_q <= 1'b0;
                    end else if (!en_i || clear_i) begin
                        state_q    <= IDLE;
                        tx_start_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (tx_rdy_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_WM_EN
    logic tx_wm_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wm_q <= 1'b1;
        end else begin
            tx_wm_q <= (level_o <= wm_level_i);
        end
    end

    assign tx_wm_o = tx_wm_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 9;
    localparam int LW    = 5;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          clear;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_rdy;
`ifdef UART_TX_FIFO_WM_EN
    logic [LW-1:0] wm_level;
    logic          tx_wm;
`endif

    int tests  = 0;
    int failed = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .clear_i    (clear),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .overflow_o (overflow),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .tx_rdy_i   (tx_rdy)
`ifdef UART_TX_FIFO_WM_EN
        ,
        .wm_level_i (wm_level),
        .tx_wm_o    (tx_wm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] d;
        logic          rdy;
        logic          en;
        logic          clr;
        logic          e_start;
        logic [LW-1:0] e_level;
        logic          e_empty;
        logic          e_full;
        logic          e_ovf;
        logic          chk_data;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [DW-1:0] d, input logic rdy, input logic e,
                       input logic clr, input logic s, input logic [LW-1:0] lv, input logic emp,
                       input logic cd, input logic [DW-1:0] ed);
        vec_t v;
        v.wr = wr; v.d = d; v.rdy = rdy; v.en = e; v.clr = clr;
        v.e_start = s; v.e_level = lv; v.e_empty = emp; v.e_full = 1'b0; v.e_ovf = 1'b0;
        v.chk_data = cd; v.e_data = ed;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rdy,
                         input logic e, input logic clr);
        wr_en = wr; wr_data = d; tx_rdy = rdy; en = e; clear = clr;
    endtask

    initial begin
        bit seen;

        rst_n = 1'b0; en = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; tx_rdy = 1'b1;
`ifdef UART_TX_FIFO_WM_EN
        wm_level = 5'd2;
`endif
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_start", 32'(tx_start), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_ovf", 32'(overflow), 32'd0);

        //   wr  data    rdy  en   clr  start lvl emp  chkd data
        add(1, 9'h055, 1, 1, 0,   0, 1, 0,   1, 9'h055); // push at edge k
        add(0, 9'h000, 1, 1, 0,   1, 1, 0,   1, 9'h055); // start after k+1
        add(0, 9'h000, 0, 1, 0,   0, 0, 1,   0, 9'h000); // accepted: pop, start drops
        add(0, 9'h000, 0, 1, 0,   0, 0, 1,   0, 9'h000); // busy
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000); // frame done
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000);
        add(1, 9'h0A1, 1, 0, 0,   0, 1, 0,   1, 9'h0A1); // en low: queued, no launch
        add(0, 9'h000, 1, 0, 0,   0, 1, 0,   1, 9'h0A1);
        add(0, 9'h000, 1, 0, 0,   0, 1, 0,   1, 9'h0A1);
        add(0, 9'h000, 1, 1, 0,   1, 1, 0,   1, 9'h0A1); // enable -> launch
        add(0, 9'h000, 1, 1, 1,   0, 0, 1,   0, 9'h000); // clear in LAUNCH
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000);
        add(1, 9'h1B2, 1, 1, 0,   0, 1, 0,   1, 9'h1B2);
        add(0, 9'h000, 1, 1, 0,   1, 1, 0,   1, 9'h1B2);
        add(0, 9'h000, 0, 1, 0,   0, 0, 1,   0, 9'h000); // BUSY
        add(1, 9'h003, 0, 1, 0,   0, 1, 0,   1, 9'h003);
        add(0, 9'h000, 0, 1, 1,   0, 0, 1,   0, 9'h000); // clear in BUSY
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000); // frame done
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000); // no further start
        add(1, 9'h0C4, 1, 1, 0,   0, 1, 0,   1, 9'h0C4);
        add(0, 9'h000, 1, 1, 0,   1, 1, 0,   1, 9'h0C4);
        add(0, 9'h000, 0, 1, 1,   0, 0, 1,   0, 9'h000); // accept + clear same edge
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000);
        add(0, 9'h000, 1, 1, 0,   0, 0, 1,   0, 9'h000);

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].d, vecs[i].rdy, vecs[i].en, vecs[i].clr);
            step();
            chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].e_start));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].e_data));
        end

        // Fill past full with the transmitter busy; 17th word must be dropped.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1, DW'(i), 0, 1, 0);
            step();
            if (i == DEPTH - 1) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_ovf_pre", 32'(overflow), 32'd0);
            end
        end
        drive(0, '0, 0, 1, 0);
        chk("ovf_level", 32'(level), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_start", 32'(tx_start), 32'd0);

        // Drain with a simple transmitter model; order must wrap through rd_ptr.
        for (int i = 0; i < DEPTH; i++) begin
            tx_rdy = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                step();
                if (tx_start) seen = 1'b1;
            end
            chk($sformatf("drain%0d_start", i), 32'(seen), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(tx_data), 32'(i));
            tx_rdy = 1'b0;
            step();
        end
        tx_rdy = 1'b1;
        step();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);
        step();
        chk("drain_no_start", 32'(tx_start), 32'd0);
        drive(0, '0, 1, 1, 1);
        step();
        clear = 1'b0;
        chk("clear_ovf", 32'(overflow), 32'd0);

        // Level 5, then accept and push on the same edge.
        for (int i = 0; i < 5; i++) begin
            drive(1, DW'(9'h010 + i), 0, 1, 0);
            step();
        end
        drive(0, '0, 1, 1, 0);
        step();
        chk("l5_start", 32'(tx_start), 32'd1);
        chk("l5_head0", 32'(tx_data), 32'h010);
        drive(1, 9'h015, 0, 1, 0);
        step();
        chk("l5_level", 32'(level), 32'd5);
        chk("l5_head1", 32'(tx_data), 32'h011);
        chk("l5_start_off", 32'(tx_start), 32'd0);
        drive(0, '0, 0, 1, 1);
        step();
        drive(0, '0, 1, 1, 0);
        step();
        chk("l5_cleared", 32'(level), 32'd0);

`ifdef UART_TX_FIFO_WM_EN
        // wm_level=2: level 3 -> 2 raises tx_wm one edge later.
        for (int i = 0; i < 3; i++) begin
            drive(1, DW'(i), 0, 1, 0);
            step();
        end
        drive(0, '0, 0, 1, 0);
        step();
        chk("wm_low", 32'(tx_wm), 32'd0);
        tx_rdy = 1'b1;
        step();
        tx_rdy = 1'b0;
        step();
        chk("wm_lvl2", 32'(level), 32'd2);
        chk("wm_still_low", 32'(tx_wm), 32'd0);
        step();
        chk("wm_rise", 32'(tx_wm), 32'd1);
        drive(0, '0, 0, 1, 1);
        step();
        drive(0, '0, 1, 1, 0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
